// File: rtl/div_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_iter : radix-2 restoring divider for DIV/DIVU/REM/REMU, 1 bit/clock   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              is_rem_q, is_rem_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              div_zero, ovf;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   trial;
  logic              trial_ok;
  logic [XLEN-1:0]   step_rem, step_quo, fin_res;
  logic              last;

  // Magnitudes are taken as unsigned, so |-2^(XLEN-1)| wraps to 2^(XLEN-1).
  assign a_neg    = is_signed & dividend[XLEN-1];
  assign b_neg    = is_signed & divisor[XLEN-1];
  assign a_abs    = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_abs    = b_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

  // One restoring step; the extra top bit of trial is the borrow.
  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, dsr_q};
  assign trial_ok = ~trial[XLEN+1];
  assign step_rem = trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign step_quo = {quo_q[XLEN-2:0], trial_ok};
  assign last     = (count_q == CW'(XLEN - 1));

  always_comb begin
    fin_res = step_quo;
    if (is_rem_q) begin
      fin_res = neg_r_q ? (~step_rem + 1'b1) : step_rem;
    end else if (neg_q_q) begin
      fin_res = ~step_quo + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    result_d = result_q;
    is_rem_d = is_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          is_rem_d = is_rem;
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          rem_d    = '0;
          quo_d    = a_abs;
          dsr_d    = b_abs;
          count_d  = '0;
          if (div_zero) begin
            state_d  = S_DONE;
            result_d = is_rem ? dividend : '1;
          end else if (ovf) begin
            state_d  = S_DONE;
            result_d = is_rem ? '0 : dividend;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + CW'(1);
        if (last) begin
          state_d  = S_DONE;
          result_d = fin_res;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

    // A redirect wins over any accept, iteration or hand-off this edge.
    if (flush) begin
      state_d  = S_IDLE;
      count_d  = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      result_q <= result_d;
      is_rem_q <= is_rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_div_iter : randomized and directed bench for div_iter                  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_div_iter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            is_signed = 1'b0;
  logic            is_rem = 1'b0;
  logic [XLEN-1:0] dividend = '0;
  logic [XLEN-1:0] divisor = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            busy;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  div_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_signed(is_signed), .is_rem(is_rem), .dividend(dividend), .divisor(divisor),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : a;
      return r ? 32'(sa % sb) : 32'(sa / sb);
    end
    return r ? (a % b) : (a / b);
  endfunction

  function automatic logic is_special(input logic [31:0] a, input logic [31:0] b, input logic s);
    return (b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Transaction-level timing model: idle / counting down / holding a result.
  logic        m_idle = 1'b1;
  logic        m_valid = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_res   <= '0;
    end else if (flush) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_left  <= 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle <= 1'b0;
        if (is_special(dividend, divisor, is_signed)) begin
          m_valid <= 1'b1;
          m_res   <= ref_res(dividend, divisor, is_signed, is_rem);
        end else begin
          m_left <= XLEN;
          m_pend <= ref_res(dividend, divisor, is_signed, is_rem);
        end
      end
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_res   <= m_pend;
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check32("in_ready", {31'd0, in_ready}, {31'd0, m_idle});
      check32("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check32("busy", {31'd0, busy}, {31'd0, ~m_idle});
      if (m_valid) check32("result", result, m_res);
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic r, input int hold, input logic lit_chk,
                        input logic [31:0] lit, input int lat);
    int cyc;
    @(posedge clk); #2;
    in_valid = 1'b1; dividend = a; divisor = b; is_signed = s; is_rem = r; out_ready = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b0;
    dividend = $urandom; divisor = $urandom;
    is_signed = 1'($urandom); is_rem = 1'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
    end
    if (!out_valid) begin
      failures++;
      checks++;
      $display("FAIL timeout: no out_valid after %0d cycles", cyc);
    end
    if (lit_chk) begin
      check32("latency", 32'(cyc), 32'(lat));
      check32("lit_result", result, lit);
      check32("model_pin", m_res, lit);
    end
    repeat (hold) begin
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    int sel;
    repeat (3) @(posedge clk);
    #2;
    check32("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_result", result, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 1'b0, 0, 1'b1, 32'd14, 33);
    run_op(32'd100, 32'd7, 1'b0, 1'b1, 0, 1'b1, 32'd2, 33);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0, 1'b1, 32'hFFFF_FFFD, 33);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 0, 1'b1, 32'hFFFF_FFFF, 33);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 0, 1'b1, 32'd1, 33);
    run_op(32'h1234, 32'd0, 1'b0, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 1);
    run_op(32'h1234, 32'd0, 1'b0, 1'b1, 0, 1'b1, 32'h1234, 1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b1, 32'h8000_0000, 1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 1'b1, 32'd0, 1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 5, 1'b1, 32'hFFFF_FFFF, 33);
    run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, 0, 1'b1, 32'h8000_0000, 33);

    // Flush after ten iterations.
    @(posedge clk); #2;
    in_valid = 1'b1; dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; is_rem = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    check32("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check32("flush_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #2;
    run_op(32'd100, 32'd7, 1'b0, 1'b0, 0, 1'b1, 32'd14, 33);

    // Flush beats in_valid in IDLE.
    @(posedge clk); #2;
    in_valid = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd0;
    @(posedge clk); #2;
    in_valid = 1'b0; flush = 1'b0;
    check32("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Flush in DONE discards the result even with out_ready high.
    @(posedge clk); #2;
    in_valid = 1'b1; dividend = 32'd5; divisor = 32'd0; is_signed = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b0;
    check32("done_out_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0; out_ready = 1'b0;
    check32("flush_done_out_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-calculation.
    @(posedge clk); #2;
    in_valid = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check32("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check32("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check32("arst_busy", {31'd0, busy}, 32'd0);
    check32("arst_result", result, 32'd0);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 255);
        default: a = $urandom;
      endcase
      run_op(a, b, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0, 32'd0, 0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
